// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//
// Bundles everything that passes between the multicycle controller and the
// datapath/memory side. clk and rst stay plain ports on the modules.
//
// Parameters
//   OPW  opcode field width (only 6 is supported)
//   SW   width of the state debug output
//
// Signals
//   opcode     instruction-register opcode field       datapath -> ctrl
//   zero       ALU zero flag                           datapath -> ctrl
//   mem_ready  memory access completes this cycle      memory   -> ctrl
//   pc_en, ir_en, ab_en, alu_out_en, mdr_en            register enables
//   reg_we, mem_rd, mem_wr                             write/read strobes
//   iord, alu_src_a, reg_dst, mem_to_reg               1-bit mux selects
//   alu_src_b, alu_op, pc_src                          2-bit selects/ALU class
//   state      current controller state (debug)
//   illegal    one-cycle pulse on an unknown opcode
//
// Modports
//   master  the controller (drives the control outputs)
//   slave   the datapath/memory side (drives opcode, zero, mem_ready)
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int unsigned OPW = 6,
    parameter int unsigned SW  = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;

    logic           pc_en;
    logic           ir_en;
    logic           ab_en;
    logic           alu_out_en;
    logic           mdr_en;
    logic           reg_we;
    logic           mem_rd;
    logic           mem_wr;
    logic           iord;
    logic           alu_src_a;
    logic           reg_dst;
    logic           mem_to_reg;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_src;
    logic [SW-1:0]  state;
    logic           illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, ir_en, ab_en, alu_out_en, mdr_en,
        output reg_we, mem_rd, mem_wr,
        output iord, alu_src_a, reg_dst, mem_to_reg,
        output alu_src_b, alu_op, pc_src,
        output state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, ir_en, ab_en, alu_out_en, mdr_en,
        input  reg_we, mem_rd, mem_wr,
        input  iord, alu_src_a, reg_dst, mem_to_reg,
        input  alu_src_b, alu_op, pc_src,
        input  state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for a classic multicycle MIPS-style datapath. Control
// outputs are decoded from the current state (Moore), except that the enables
// tied to a memory access are qualified by mem_ready and pc_en in BRANCH
// follows the ALU zero flag.
//
// Parameters
//   OPW  opcode field width (only 6 is supported)
//   SW   width of the state debug output (>= 4)
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset; forces FETCH immediately
//   bus   multicycle_ctrl_if.master: opcode/zero/mem_ready in, controls out
//
// Configuration
//   MULTICYCLE_HALT_EN  when defined, opcode 6'h3F decodes to a HALT state
//                       that drives all outputs 0 and is left only by reset.
//                       When undefined, 6'h3F is treated as illegal.
//
// State encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6
//                  RWB=7 BRANCH=8 JUMP=9 ADDIEX=10 ADDIWB=11 HALT=12
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned OPW = 6,
    parameter int unsigned SW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
`ifdef MULTICYCLE_HALT_EN
        StAddiWb = 4'd11,
        StHalt   = 4'd12
`else
        StAddiWb = 4'd11
`endif
    } state_e;

    localparam logic [OPW-1:0] OpRtype = OPW'(6'h00);
    localparam logic [OPW-1:0] OpLw    = OPW'(6'h23);
    localparam logic [OPW-1:0] OpSw    = OPW'(6'h2B);
    localparam logic [OPW-1:0] OpBeq   = OPW'(6'h04);
    localparam logic [OPW-1:0] OpJ     = OPW'(6'h02);
    localparam logic [OPW-1:0] OpAddi  = OPW'(6'h08);
`ifdef MULTICYCLE_HALT_EN
    localparam logic [OPW-1:0] OpHalt  = OPW'(6'h3F);
`endif

    state_e state_q, state_d;

    logic [OPW-1:0] op;
    assign op = bus.opcode;

    // Unmasked decode results; masked with rst before leaving the module.
    logic       pc_en_c, ir_en_c, ab_en_c, alu_out_en_c, mdr_en_c;
    logic       reg_we_c, mem_rd_c, mem_wr_c;
    logic       iord_c, alu_src_a_c, reg_dst_c, mem_to_reg_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;
    logic       illegal_c;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_en_c      = 1'b0;
        ir_en_c      = 1'b0;
        ab_en_c      = 1'b0;
        alu_out_en_c = 1'b0;
        mdr_en_c     = 1'b0;
        reg_we_c     = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        iord_c       = 1'b0;
        alu_src_a_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        pc_src_c     = 2'b00;
        illegal_c    = 1'b0;

        case (state_q)
            StFetch: begin
                // PC+4 computed alongside the instruction read; both registers
                // load only in the cycle the read completes.
                mem_rd_c    = 1'b1;
                alu_src_b_c = 2'b01;
                ir_en_c     = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end
            end

            StDecode: begin
                // Register read plus speculative branch target into ALUOut.
                ab_en_c      = 1'b1;
                alu_out_en_c = 1'b1;
                alu_src_b_c  = 2'b11;
                case (op)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
`ifdef MULTICYCLE_HALT_EN
                    OpHalt:     state_d = StHalt;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end

            StMemAdr: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                alu_out_en_c = 1'b1;
                state_d      = (op == OpLw) ? StMemRd : StMemWr;
            end

            StMemRd: begin
                mem_rd_c = 1'b1;
                iord_c   = 1'b1;
                mdr_en_c = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end
            end

            StMemWb: begin
                reg_we_c     = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = StFetch;
            end

            StMemWr: begin
                // Strobe stays high across a stall until memory accepts it.
                mem_wr_c = 1'b1;
                iord_c   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end
            end

            StExec: begin
                alu_src_a_c  = 1'b1;
                alu_op_c     = 2'b10;
                alu_out_en_c = 1'b1;
                state_d      = StRwb;
            end

            StRwb: begin
                reg_we_c  = 1'b1;
                reg_dst_c = 1'b1;
                state_d   = StFetch;
            end

            StBranch: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b01;
                pc_src_c    = 2'b01;
                pc_en_c     = bus.zero;
                state_d     = StFetch;
            end

            StJump: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
                state_d  = StFetch;
            end

            StAddiEx: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                alu_out_en_c = 1'b1;
                state_d      = StAddiWb;
            end

            StAddiWb: begin
                reg_we_c = 1'b1;
                state_d  = StFetch;
            end

`ifdef MULTICYCLE_HALT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif

            default: begin
                // Unreachable encodings recover to FETCH with outputs quiet.
                state_d = StFetch;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. FETCH decodes mem_rd/pc_en/ir_en, so every output is gated by
    // rst to keep the datapath quiet while reset is held.
    // -------------------------------------------------------------------------
    assign bus.pc_en      = rst & pc_en_c;
    assign bus.ir_en      = rst & ir_en_c;
    assign bus.ab_en      = rst & ab_en_c;
    assign bus.alu_out_en = rst & alu_out_en_c;
    assign bus.mdr_en     = rst & mdr_en_c;
    assign bus.reg_we     = rst & reg_we_c;
    assign bus.mem_rd     = rst & mem_rd_c;
    assign bus.mem_wr     = rst & mem_wr_c;
    assign bus.iord       = rst & iord_c;
    assign bus.alu_src_a  = rst & alu_src_a_c;
    assign bus.reg_dst    = rst & reg_dst_c;
    assign bus.mem_to_reg = rst & mem_to_reg_c;
    assign bus.alu_src_b  = rst ? alu_src_b_c : 2'b00;
    assign bus.alu_op     = rst ? alu_op_c    : 2'b00;
    assign bus.pc_src     = rst ? pc_src_c    : 2'b00;
    assign bus.illegal    = rst & illegal_c;
    assign bus.state      = SW'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Table-driven bench for multicycle_ctrl plus hand-written sequences for
// instruction cycle counts, asynchronous reset mid-instruction and HALT.
// Output word bit order (MSB first):
//   pc_en ir_en ab_en alu_out_en | mdr_en reg_we mem_rd mem_wr |
//   iord alu_src_a reg_dst mem_to_reg | alu_src_b[1:0] | alu_op[1:0] |
//   pc_src[1:0] | illegal
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_ctrl_if ifc ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Hand-computed expected output words per state.
    localparam logic [18:0] O_ZERO  = 19'b0000_0000_0000_00_00_00_0;
    localparam logic [18:0] O_F_RDY = 19'b1100_0010_0000_01_00_00_0;
    localparam logic [18:0] O_F_STL = 19'b0000_0010_0000_01_00_00_0;
    localparam logic [18:0] O_DEC   = 19'b0011_0000_0000_11_00_00_0;
    localparam logic [18:0] O_DEC_I = 19'b0011_0000_0000_11_00_00_1;
    localparam logic [18:0] O_MADR  = 19'b0001_0000_0100_10_00_00_0;
    localparam logic [18:0] O_MRD_R = 19'b0000_1010_1000_00_00_00_0;
    localparam logic [18:0] O_MRD_S = 19'b0000_0010_1000_00_00_00_0;
    localparam logic [18:0] O_MWB   = 19'b0000_0100_0001_00_00_00_0;
    localparam logic [18:0] O_MWR   = 19'b0000_0001_1000_00_00_00_0;
    localparam logic [18:0] O_EXEC  = 19'b0001_0000_0100_00_10_00_0;
    localparam logic [18:0] O_RWB   = 19'b0000_0100_0010_00_00_00_0;
    localparam logic [18:0] O_BR_T  = 19'b1000_0000_0100_00_01_01_0;
    localparam logic [18:0] O_BR_N  = 19'b0000_0000_0100_00_01_01_0;
    localparam logic [18:0] O_JUMP  = 19'b1000_0000_0000_00_00_10_0;
    localparam logic [18:0] O_ADDEX = 19'b0001_0000_0100_10_00_00_0;
    localparam logic [18:0] O_ADDWB = 19'b0000_0100_0000_00_00_00_0;

    logic [18:0] act_out;
    assign act_out = {ifc.pc_en, ifc.ir_en, ifc.ab_en, ifc.alu_out_en,
                      ifc.mdr_en, ifc.reg_we, ifc.mem_rd, ifc.mem_wr,
                      ifc.iord, ifc.alu_src_a, ifc.reg_dst, ifc.mem_to_reg,
                      ifc.alu_src_b, ifc.alu_op, ifc.pc_src, ifc.illegal};

    typedef struct {
        logic [5:0]  opcode;
        logic        zero;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [18:0] exp_out;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [18:0] o);
        vec_t v;
        v.opcode    = op;
        v.zero      = z;
        v.mem_ready = rdy;
        v.exp_state = st;
        v.exp_out   = o;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // From FETCH at a negedge: count rising edges until FETCH is reached again.
    task automatic count_cycles(input string name, input logic [5:0] op, input int exp);
        int n;
        ifc.opcode    = op;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifc.state != 4'd0 && n < 20);
        check(name, 0, n, exp);
    endtask

    initial begin
        // R-type
        add(6'h00, 0, 1, 4'd0, O_F_RDY);
        add(6'h00, 0, 1, 4'd1, O_DEC);
        add(6'h00, 0, 1, 4'd6, O_EXEC);
        add(6'h00, 0, 1, 4'd7, O_RWB);
        // LW with a 3-cycle stall in MEMRD
        add(6'h23, 0, 1, 4'd0, O_F_RDY);
        add(6'h23, 0, 1, 4'd1, O_DEC);
        add(6'h23, 0, 1, 4'd2, O_MADR);
        add(6'h23, 0, 0, 4'd3, O_MRD_S);
        add(6'h23, 0, 0, 4'd3, O_MRD_S);
        add(6'h23, 0, 0, 4'd3, O_MRD_S);
        add(6'h23, 0, 1, 4'd3, O_MRD_R);
        add(6'h23, 0, 1, 4'd4, O_MWB);
        // SW with a 1-cycle stall in MEMWR
        add(6'h2B, 0, 1, 4'd0, O_F_RDY);
        add(6'h2B, 0, 1, 4'd1, O_DEC);
        add(6'h2B, 0, 1, 4'd2, O_MADR);
        add(6'h2B, 0, 0, 4'd5, O_MWR);
        add(6'h2B, 0, 1, 4'd5, O_MWR);
        // BEQ taken / not taken
        add(6'h04, 1, 1, 4'd0, O_F_RDY);
        add(6'h04, 1, 1, 4'd1, O_DEC);
        add(6'h04, 1, 1, 4'd8, O_BR_T);
        add(6'h04, 0, 1, 4'd0, O_F_RDY);
        add(6'h04, 0, 1, 4'd1, O_DEC);
        add(6'h04, 0, 1, 4'd8, O_BR_N);
        // J
        add(6'h02, 0, 1, 4'd0, O_F_RDY);
        add(6'h02, 0, 1, 4'd1, O_DEC);
        add(6'h02, 0, 1, 4'd9, O_JUMP);
        // ADDI
        add(6'h08, 0, 1, 4'd0, O_F_RDY);
        add(6'h08, 0, 1, 4'd1, O_DEC);
        add(6'h08, 0, 1, 4'd10, O_ADDEX);
        add(6'h08, 0, 1, 4'd11, O_ADDWB);
        // Illegal opcode, then fetch stall and another illegal opcode
        add(6'h15, 0, 1, 4'd0, O_F_RDY);
        add(6'h15, 0, 1, 4'd1, O_DEC_I);
        add(6'h00, 0, 0, 4'd0, O_F_STL);
        add(6'h00, 0, 0, 4'd0, O_F_STL);
        add(6'h00, 0, 1, 4'd0, O_F_RDY);
        add(6'h21, 0, 1, 4'd1, O_DEC_I);
        add(6'h00, 0, 0, 4'd0, O_F_STL);

        // Reset: outputs quiet even though FETCH would assert mem_rd/pc_en/ir_en
        ifc.opcode    = 6'h00;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_state", 0, 32'(ifc.state), 32'd0);
        check("reset_outs", 0, 32'(act_out), 32'(O_ZERO));
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1, 32'(ifc.state), 32'd0);
        check("reset_outs", 1, 32'(act_out), 32'(O_ZERO));

        @(negedge clk);
        rst = 1'b1;
        foreach (vecs[i]) begin
            ifc.opcode    = vecs[i].opcode;
            ifc.zero      = vecs[i].zero;
            ifc.mem_ready = vecs[i].mem_ready;
            #1;
            check("vec_state", i, 32'(ifc.state), 32'(vecs[i].exp_state));
            check("vec_outs", i, 32'(act_out), 32'(vecs[i].exp_out));
            @(negedge clk);
        end

        // Cycle counts with mem_ready stuck at 1
        count_cycles("cycles_rtype", 6'h00, 4);
        count_cycles("cycles_lw", 6'h23, 5);
        count_cycles("cycles_sw", 6'h2B, 4);
        count_cycles("cycles_beq", 6'h04, 3);
        count_cycles("cycles_j", 6'h02, 3);
        count_cycles("cycles_addi", 6'h08, 4);
        count_cycles("cycles_illegal", 6'h15, 2);

        // Asynchronous reset in the middle of a stalled MEMWR
        ifc.opcode    = 6'h2B;
        ifc.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ifc.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("memwr_state", 0, 32'(ifc.state), 32'd5);
        check("memwr_strobe", 0, 32'(ifc.mem_wr), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", 0, 32'(ifc.state), 32'd0);
        check("async_rst_memwr", 0, 32'(ifc.mem_wr), 32'd0);
        check("async_rst_outs", 0, 32'(act_out), 32'(O_ZERO));
        ifc.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("async_rst_state", 1, 32'(ifc.state), 32'd0);
        check("async_rst_outs", 1, 32'(act_out), 32'(O_ZERO));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_outs", 0, 32'(act_out), 32'(O_F_RDY));
        @(negedge clk);
        check("post_rst_state", 0, 32'(ifc.state), 32'd1);
        ifc.opcode = 6'h15;
        @(negedge clk);
        check("post_rst_state", 1, 32'(ifc.state), 32'd0);

        // Opcode 6'h3F: HALT when enabled, illegal otherwise
        ifc.opcode = 6'h3F;
        @(negedge clk);
        #1;
`ifdef MULTICYCLE_HALT_EN
        check("op3f_decode", 0, 32'(act_out), 32'(O_DEC));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("halt_state", k, 32'(ifc.state), 32'd12);
            check("halt_outs", k, 32'(act_out), 32'(O_ZERO));
        end
        rst = 1'b0;
        #1;
        check("halt_rst_state", 0, 32'(ifc.state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
`else
        check("op3f_decode", 0, 32'(act_out), 32'(O_DEC_I));
        @(negedge clk);
        check("op3f_next", 0, 32'(ifc.state), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPW, default 6, opcode field width; only 6 is supported.
REQ-002 Parameter SW, default 4, width of the state debug output.
REQ-003 clk  input  1  system clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  OPW  opcode from the instruction register output.
REQ-006 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  input  1  memory handshake; the current memory access completes in a cycle with mem_ready=1.
REQ-008 pc_en, ir_en, ab_en, alu_out_en, mdr_en  output  1 each  enables for the PC, IR, A/B, ALUOut and MDR enable-registers.
REQ-009 reg_we, mem_rd, mem_wr  output  1 each  register-file write, memory read and memory write strobes.
REQ-010 iord, alu_src_a, reg_dst, mem_to_reg  output  1 each  datapath mux selects.
REQ-011 alu_src_b, alu_op, pc_src  output  2 each  datapath mux selects and ALU opcode class.
REQ-012 state  output  SW  current state encoding.
REQ-013 illegal  output  1  one-cycle pulse on an unknown opcode.

Function
REQ-014 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12.
REQ-015 Outputs are Moore-decoded from state, except pc_en in BRANCH and the ready-qualified enables; all unlisted outputs are 0.
REQ-016 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_en=pc_en=mem_ready; go to DECODE when mem_ready=1, else hold.
REQ-017 DECODE: ab_en=1, alu_out_en=1, alu_src_b=11, alu_op=00; next state is set by opcode.
REQ-018 DECODE opcode map: 6'h00->EXEC; 6'h23 and 6'h2B->MEMADR; 6'h04->BRANCH; 6'h02->JUMP; 6'h08->ADDIEX; any other value->FETCH with illegal=1 for that cycle.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_out_en=1; opcode 6'h23->MEMRD, else->MEMWR.
REQ-020 MEMRD: mem_rd=1, iord=1, mdr_en=mem_ready; go to MEMWB on mem_ready, else hold.
REQ-021 MEMWB: reg_we=1, mem_to_reg=1, reg_dst=0; go to FETCH.
REQ-022 MEMWR: mem_wr=1, iord=1; go to FETCH on mem_ready, else hold with mem_wr held at 1.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, alu_out_en=1; go to RWB.
REQ-024 RWB: reg_we=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; go to FETCH.
REQ-026 JUMP: pc_src=10, pc_en=1; go to FETCH.
REQ-027 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, alu_out_en=1; go to ADDIWB.
REQ-028 ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-029 Cycle counts with mem_ready stuck at 1: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
REQ-030 Unreachable encodings 13-15 go to FETCH on the next edge with all outputs 0.
REQ-031 A memory stall never asserts more than one register enable per completed access.

Reset
REQ-032 rst=0 forces FETCH immediately, mid-instruction included, without waiting for clk.
REQ-033 While rst=0, all enables and strobes are 0, illegal=0 and state=0; pc_en, ir_en and mem_rd are masked during reset.
REQ-034 After rst rises, the first rising edge evaluates FETCH normally.

Configuration
REQ-035 Macro MULTICYCLE_HALT_EN: when defined, opcode 6'h3F in DECODE goes to HALT.
REQ-036 With MULTICYCLE_HALT_EN defined, HALT drives all outputs 0 and is left only by reset.
REQ-037 Without MULTICYCLE_HALT_EN, the HALT state is absent and 6'h3F is illegal under REQ-018.

Verification
REQ-038 Reset with mem_ready=1, then opcode 6'h00 -> states 0,1,6,7,0; reg_we=1 only in state 7, with reg_dst=1.
REQ-039 Opcode 6'h23, mem_ready=0 for 3 cycles in MEMRD -> state holds at 3 for 3 cycles; mdr_en=1 exactly once; then MEMWB.
REQ-040 Opcode 6'h04: with zero=1 -> pc_en=1 and pc_src=01 in state 8; with zero=0 -> pc_en=0; both then go to FETCH.
REQ-041 Opcode 6'h15 -> illegal=1 for one cycle in DECODE; next state 0; no reg_we or mem_wr is asserted.
REQ-042 rst dropped to 0 mid-MEMWR -> state=0 and mem_wr=0 before the next clock edge.
REQ-043 MULTICYCLE_HALT_EN defined, opcode 6'h3F -> state 12 held for 20 cycles; only reset exits it.
